// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: widths, shift
// direction codes, controller state encoding and the set-bit search helper.
package shift_defs;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    localparam logic DIR_SLL = 1'b0;
    localparam logic DIR_SRA = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Returns {found, index} of the highest set bit of amt strictly below
    // position lim. Passing lim=5 searches the whole shift amount.
    function automatic logic [3:0] next_set_below(input logic [SHAMT_W-1:0] amt,
                                                  input logic [2:0]         lim);
        logic [3:0] r;
        r = 4'b0;
        for (int i = 0; i < SHAMT_W; i++) begin
            if ((i < int'(lim)) && amt[i]) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_sequencer_stage.sv
// Single shared shift stage: moves the data by 2^k bits, zero filling for a
// logical left shift and replicating bit 31 for an arithmetic right shift.
module var_stage_shifter
    import shift_defs::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [2:0]        k,
    input  logic              dir,
    output logic [DATA_W-1:0] shifted
);

    // Select one of the five power-of-two shift distances; unused k codes pass through.
    always_comb begin
        shifted = data;
        case (k)
            3'd0: shifted = (dir == DIR_SRA) ? {{1{data[DATA_W-1]}},  data[DATA_W-1:1]}
                                             : {data[DATA_W-2:0],  1'b0};
            3'd1: shifted = (dir == DIR_SRA) ? {{2{data[DATA_W-1]}},  data[DATA_W-1:2]}
                                             : {data[DATA_W-3:0],  2'b0};
            3'd2: shifted = (dir == DIR_SRA) ? {{4{data[DATA_W-1]}},  data[DATA_W-1:4]}
                                             : {data[DATA_W-5:0],  4'b0};
            3'd3: shifted = (dir == DIR_SRA) ? {{8{data[DATA_W-1]}},  data[DATA_W-1:8]}
                                             : {data[DATA_W-9:0],  8'b0};
            3'd4: shifted = (dir == DIR_SRA) ? {{16{data[DATA_W-1]}}, data[DATA_W-1:16]}
                                             : {data[DATA_W-17:0], 16'b0};
            default: shifted = data;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: accepts one SLL/SRA request at a time and walks
// the 16/8/4/2/1 stages one per clock through a single shared stage shifter.
module shift_sequencer
    import shift_defs::*;
#(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               dir,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [DATA_W-1:0]  operand,
    output logic               ready,
    output logic               busy,
    output logic               result_valid,
    output logic [DATA_W-1:0]  result
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   work_q, work_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [SHAMT_W-1:0]  amt_q, amt_d;
    logic                dir_q, dir_d;
    logic [2:0]          k_q, k_d;
    logic [DATA_W-1:0]   stage_out;
    logic [DATA_W-1:0]   work_after;
    logic [3:0]          first_set;
    logic [3:0]          next_set;
    logic                accept;
    logic                last_stage;

    var_stage_shifter u_stage (
        .data    (work_q),
        .k       (k_q),
        .dir     (dir_q),
        .shifted (stage_out)
    );

    // Next-state logic: capture on accept, one stage per edge in SHIFT, and
    // publish the result on the edge that enters DONE.
    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        result_d   = result_q;
        amt_d      = amt_q;
        dir_d      = dir_q;
        k_d        = k_q;
        accept     = start && (state_q != SHIFT);
        first_set  = next_set_below(shamt, 3'd5);
        next_set   = next_set_below(amt_q, k_q);
        work_after = amt_q[k_q] ? stage_out : work_q;
        last_stage = SKIP_ZERO ? !next_set[3] : (k_q == 3'd0);

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (accept) begin
                    work_d = operand;
                    amt_d  = shamt;
                    dir_d  = dir;
                    if (SKIP_ZERO) begin
                        // Skip mode starts at the highest set bit, so only set stages cost an edge.
                        if (first_set[3]) begin
                            k_d     = first_set[2:0];
                            state_d = SHIFT;
                        end else begin
                            k_d      = 3'd0;
                            state_d  = DONE;
                            result_d = operand;
                        end
                    end else begin
                        k_d     = 3'd4;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d = work_after;
                if (last_stage) begin
                    state_d  = DONE;
                    result_d = work_after;
                end else begin
                    k_d = SKIP_ZERO ? next_set[2:0] : (k_q - 3'd1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            work_q   <= '0;
            result_q <= '0;
            amt_q    <= '0;
            dir_q    <= DIR_SLL;
            k_q      <= 3'd0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            result_q <= result_d;
            amt_q    <= amt_d;
            dir_q    <= dir_d;
            k_q      <= k_d;
        end
    end

    assign ready        = (state_q == IDLE) || (state_q == DONE);
    assign busy         = (state_q == SHIFT);
    assign result_valid = (state_q == DONE);
    assign result       = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed testbench for shift_sequencer: one fixed-latency and one skip-mode
// instance share the same stimulus; expected values are hand-computed constants.
module tb_shift_sequencer;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        dir;
    logic [4:0]  shamt;
    logic [31:0] operand;

    logic        ready0, busy0, valid0;
    logic [31:0] result0;
    logic        ready1, busy1, valid1;
    logic [31:0] result1;

    int checks;
    int passes;

    shift_sequencer #(.SKIP_ZERO(1'b0)) dut0 (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .dir          (dir),
        .shamt        (shamt),
        .operand      (operand),
        .ready        (ready0),
        .busy         (busy0),
        .result_valid (valid0),
        .result       (result0)
    );

    shift_sequencer #(.SKIP_ZERO(1'b1)) dut1 (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .dir          (dir),
        .shamt        (shamt),
        .operand      (operand),
        .ready        (ready1),
        .busy         (busy1),
        .result_valid (valid1),
        .result       (result1)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Issue one operation, scramble the inputs after the accept edge, then watch
    // both instances for ten cycles and check latency, strobe width and result.
    task automatic applyStimulus(input string tag, input logic d, input logic [4:0] s,
                                 input logic [31:0] op, input logic [31:0] expv, input int n1);
        int lat0, lat1, strobes0, strobes1, busyCnt;
        logic [31:0] r0, r1;
        lat0 = -1; lat1 = -1; strobes0 = 0; strobes1 = 0; busyCnt = 0;
        r0 = '0; r1 = '0;
        @(negedge clock);
        dir = d; shamt = s; operand = op; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0; dir = ~d; shamt = ~s; operand = ~op;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin
                @(posedge clock);
                @(negedge clock);
            end
            if (valid0) begin
                strobes0++;
                if (lat0 < 0) begin lat0 = c; r0 = result0; end
            end
            if (valid1) begin
                strobes1++;
                if (lat1 < 0) begin lat1 = c; r1 = result1; end
            end
            if (busy0) busyCnt++;
        end
        checkOutput({tag, "_lat_fixed"},   32'(lat0),     32'd5);
        checkOutput({tag, "_res_fixed"},   r0,            expv);
        checkOutput({tag, "_strobe_fixed"},32'(strobes0), 32'd1);
        checkOutput({tag, "_busy_fixed"},  32'(busyCnt),  32'd5);
        checkOutput({tag, "_lat_skip"},    32'(lat1),     32'(n1));
        checkOutput({tag, "_res_skip"},    r1,            expv);
        checkOutput({tag, "_strobe_skip"}, 32'(strobes1), 32'd1);
        checkOutput({tag, "_hold_fixed"},  result0,       expv);
    endtask

    // Directed sequence: reset, single operations, busy-ignore, back-to-back, mid-shift reset.
    initial begin
        int  lat;
        int  quiet;
        logic found;
        checks = 0; passes = 0;
        reset_n = 1'b0; start = 1'b0; dir = 1'b0; shamt = 5'd0; operand = '0;

        #12;
        checkOutput("rst_ready",  32'(ready0),  32'd1);
        checkOutput("rst_busy",   32'(busy0),   32'd0);
        checkOutput("rst_valid",  32'(valid0),  32'd0);
        checkOutput("rst_result", result0,      32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        applyStimulus("sll1by31",   1'b0, 5'd31, 32'h0000_0001, 32'h8000_0000, 5);
        applyStimulus("sra8",       1'b1, 5'd8,  32'h8000_0000, 32'hFF80_0000, 1);
        applyStimulus("sra31pos",   1'b1, 5'd31, 32'h7FFF_FFFF, 32'h0000_0000, 5);
        applyStimulus("sra4",       1'b1, 5'd4,  32'hF000_0000, 32'hFF00_0000, 1);
        applyStimulus("zero_amt",   1'b0, 5'd0,  32'h1234_5678, 32'h1234_5678, 0);
        applyStimulus("sll17",      1'b0, 5'd17, 32'h0000_000F, 32'h001E_0000, 2);
        applyStimulus("sll3",       1'b0, 5'd3,  32'hA5A5_A5A5, 32'h2D2D_2D28, 2);

        // start while busy must be ignored
        @(negedge clock);
        dir = 1'b0; shamt = 5'd31; operand = 32'h0000_0001; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        lat = -1;
        for (int c = 1; c < 10; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (valid0 && lat < 0) begin
                lat = c;
                checkOutput("busy_ign_res_fixed", result0, 32'h8000_0000);
                checkOutput("busy_ign_res_skip",  result1, 32'h8000_0000);
            end
            if (c == 2 || c == 3) checkOutput("busy_ign_ready", 32'(ready0), 32'd0);
            if (c == 2) begin
                start = 1'b1; dir = 1'b1; shamt = 5'd3; operand = 32'hFFFF_0000;
            end
            if (c == 4) start = 1'b0;
        end
        checkOutput("busy_ign_lat", 32'(lat), 32'd5);

        // back-to-back accept in DONE
        @(negedge clock);
        dir = 1'b1; shamt = 5'd8; operand = 32'h8000_0000; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (valid0) begin found = 1'b1; break; end
            @(posedge clock);
            @(negedge clock);
        end
        checkOutput("b2b_first_done", 32'(found), 32'd1);
        checkOutput("b2b_first_res",  result0,    32'hFF80_0000);
        dir = 1'b0; shamt = 5'd1; operand = 32'h0000_0001; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        checkOutput("b2b_single_strobe", 32'(valid0), 32'd0);
        checkOutput("b2b_second_busy",   32'(busy0),  32'd1);
        checkOutput("b2b_result_held",   result0,     32'hFF80_0000);
        lat = -1;
        for (int c = 1; c < 10; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (valid0 && lat < 0) begin
                lat = c;
                checkOutput("b2b_second_res", result0, 32'h0000_0002);
            end
        end
        checkOutput("b2b_second_lat", 32'(lat), 32'd5);

        // asynchronous reset in the middle of SHIFT
        @(negedge clock);
        dir = 1'b0; shamt = 5'd5; operand = 32'h0000_0003; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy",   32'(busy0),  32'd0);
        checkOutput("mid_rst_valid",  32'(valid0), 32'd0);
        checkOutput("mid_rst_result", result0,     32'h0);
        checkOutput("mid_rst_ready",  32'(ready0), 32'd1);
        checkOutput("mid_rst_busy_skip", 32'(busy1), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        quiet = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (valid0 || valid1) quiet++;
        end
        checkOutput("mid_rst_no_strobe", 32'(quiet), 32'd0);
        applyStimulus("after_rst", 1'b1, 5'd1, 32'h8000_0004, 32'hC000_0002, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Hard time limit so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, got %0d checks, expected completion", checks);
        $fatal(1, "[TB] timeout");
    end

endmodule
